// File: rtl/operand_feeder.sv
// Upstream stage of the sequence adder: buffers 8-bit operands in a small FIFO
// and feeds them to the adder one frame at a time (clear, FRAME_LEN operands, done).
module operand_feeder #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       start,
    output logic [7:0] acc_data,
    output logic       acc_en,
    output logic       acc_clear,
    output logic       frame_done,
    output logic       busy,
    output logic [2:0] frame_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [2:0]  LAST_CNT = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    acc_data_q, acc_data_d;
    logic          acc_en_q, acc_en_d;
    logic [2:0]    frame_cnt_q, frame_cnt_d;
    logic          push, pop;

    // Readiness depends on registered occupancy only, so a same-cycle pop never frees a full FIFO.
    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == FEED) && (count_q != '0);

    // Storage has no reset; occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        acc_data_d  = pop ? mem_q[rd_ptr_q] : acc_data_q;
        acc_en_d    = pop;
        frame_cnt_d = frame_cnt_q;
        if (state_q == CLEAR) begin
            frame_cnt_d = 3'd0;
        end else if (pop) begin
            frame_cnt_d = frame_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_data_q  <= 8'h00;
            acc_en_q    <= 1'b0;
            frame_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_data_q  <= acc_data_d;
            acc_en_q    <= acc_en_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (pop && (frame_cnt_q == LAST_CNT)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_clear  = (state_q == CLEAR);
        frame_done = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    assign acc_data  = acc_data_q;
    assign acc_en    = acc_en_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The block SHALL be the upstream stage of the sequence adder: it buffers operands and drives the adder's data, enable and clear inputs one frame at a time.
REQ-002 Parameter DEPTH, default 4, SHALL set the operand FIFO entry count (power of two, at least 2).
REQ-003 Parameter FRAME_LEN, default 4, SHALL set the operands per frame (1..7).
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 in_data  input  8  operand offered by the producer.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  FIFO can accept an operand this cycle.
REQ-009 start  input  1  request to begin a frame.
REQ-010 acc_data  output  8  operand to the sequence adder.
REQ-011 acc_en  output  1  acc_data is to be accumulated this cycle.
REQ-012 acc_clear  output  1  sequence adder sum is to be cleared this cycle.
REQ-013 frame_done  output  1  one-cycle pulse marking the last operand of a frame.
REQ-014 busy  output  1  a frame is in progress (state not IDLE).
REQ-015 frame_cnt  output  3  operands issued in the current frame.

Function
REQ-016 FIFO push SHALL occur on a rising edge when in_valid=1 and in_ready=1, and in_ready SHALL equal not-full, computed from registered occupancy only.
REQ-017 When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-018 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH.
REQ-020 Pushes SHALL be accepted in every FSM state.
REQ-021 The FSM SHALL have four states: IDLE, CLEAR, FEED and DONE.
REQ-022 IDLE SHALL go to CLEAR when start=1, and start SHALL be ignored in every other state.
REQ-023 CLEAR SHALL last exactly one cycle, SHALL drive acc_clear=1 and SHALL clear frame_cnt to 0 on exit to FEED.
REQ-024 In FEED, a pop SHALL occur each cycle the FIFO is non-empty, and pops SHALL NOT occur in any other state.
REQ-025 Each pop SHALL register the head entry into acc_data and set acc_en=1 on the same edge, giving one-cycle latency.
REQ-026 acc_en SHALL be 0 in any cycle not preceded by a pop, and acc_data SHALL hold its last value.
REQ-027 frame_cnt SHALL increment on each pop.
REQ-028 A pop SHALL move the FSM to DONE when frame_cnt equals FRAME_LEN-1, so frame_done coincides with the final acc_en.
REQ-029 If the FIFO is empty in FEED, the FSM SHALL stall with no pop and frame_cnt held, then resume on the next non-empty cycle.
REQ-030 DONE SHALL last one cycle with frame_done=1, then return to IDLE.
REQ-031 frame_cnt SHALL hold its value in IDLE until the next CLEAR.
REQ-032 busy SHALL be 1 in CLEAR, FEED and DONE.
REQ-033 acc_clear and frame_done SHALL be decoded from the state register only.

Reset
REQ-034 While reset=0, the state SHALL be IDLE, the FIFO empty with pointers at 0, acc_data=0x00, acc_en=0, frame_cnt=0, and acc_clear, frame_done and busy all 0.
REQ-035 While reset=0, in_ready SHALL be 1.
REQ-036 Reset assertion mid-frame SHALL take effect immediately, without waiting for clk, and SHALL discard all buffered operands.
REQ-037 After reset deasserts, the first state change SHALL occur on the next rising clk edge.

Verification
REQ-038 Reset check: reset=0 at any time -> all outputs at REQ-034 values, in_ready=1.
REQ-039 Basic frame: push 0x01, 0x03, 0x33, 0xFF, then pulse start -> acc_clear for 1 cycle, then acc_en for 4 consecutive cycles carrying 01, 03, 33, FF, frame_done with FF, busy=0 the cycle after.
REQ-040 Full FIFO: 5 back-to-back pushes in IDLE -> 4 accepted, in_ready=0 after the 4th, 5th held until the first FEED pop.
REQ-041 Starvation: start with 2 entries (0x10, 0x20) -> 2 acc_en pulses, stall with frame_cnt=2, push 0x30, 0x40 -> resume, frame_done with 0x40, frame_cnt=4.
REQ-042 Mid-frame reset: reset=0 after the 2nd pop -> acc_en=0, busy=0, FIFO empty immediately, and no further pops after release.
REQ-043 Ignored start: start=1 while busy -> no extra acc_clear and no change to the frame sequence.
